// File: rtl/gene_net_pkg.sv
// gene_net_pkg
// Shared definitions for the 8-gene Boolean regulatory network blocks.
//   GENE_W    : number of genes, which is also the state vector width
//   state_t   : controller FSM states (IDLE, RUN, DONE)
//   gene_next : synchronous network update f(s). This function is the only
//               place where the regulatory rules are written down.
package gene_net_pkg;

  localparam int GENE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // One synchronous update of every gene from the current state vector.
  function automatic logic [GENE_W-1:0] gene_next(input logic [GENE_W-1:0] s);
    logic [GENE_W-1:0] n;
    n[0] = ~s[2] & s[6] & ~s[7];
    n[1] = (s[4] | s[5]) & ~s[7];
    n[2] = s[7];
    n[3] = s[1] & ~s[6];
    n[4] = s[1] | s[3];
    n[5] = s[2] & ~s[7];
    n[6] = s[1] & ~s[7];
    n[7] = ~(s[0] | s[1]) & (s[3] | s[6]);
    return n;
  endfunction

endpackage

// File: rtl/gene_net_step.sv
// gene_net_step
// Purely combinational next-state block for the gene network. Other network
// blocks reuse it, so it stays a thin wrapper around gene_net_pkg::gene_next.
// Ports:
//   state      in  GENE_W  current gene state
//   next_state out GENE_W  state after one synchronous update
module gene_net_step
  import gene_net_pkg::*;
(
  input  logic [GENE_W-1:0] state,
  output logic [GENE_W-1:0] next_state
);

  assign next_state = gene_next(state);

endmodule

// File: rtl/gene_net_ctrl.sv
// gene_net_ctrl
// Attractor-search controller. Loads a seed, steps the network once per
// clock, keeps every visited state and stops when the next state matches one
// already seen (fixed point or limit cycle) or when the step budget runs out.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start, seed         search request and its initial state (IDLE/DONE only)
//   busy                high while searching
//   done                one-cycle pulse when a search ends
//   fixed_point         attractor period is 1
//   cycle_found         attractor period is 2 or more
//   timeout             budget exhausted without a revisit
//   period, transient   attractor length and index of first revisited state
//   final_state         revisited state, or last stored state on timeout
module gene_net_ctrl
  import gene_net_pkg::*;
#(
  parameter  int MAX_STEPS = 16,
  localparam int CW        = $clog2(MAX_STEPS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [GENE_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              fixed_point,
  output logic              cycle_found,
  output logic              timeout,
  output logic [CW-1:0]     period,
  output logic [CW-1:0]     transient,
  output logic [GENE_W-1:0] final_state
);

  state_t            state;
  logic [GENE_W-1:0] hist [MAX_STEPS];
  logic [GENE_W-1:0] cur;
  logic [GENE_W-1:0] nxt;
  logic [CW-1:0]     idx;
  logic [CW-1:0]     match_idx;
  logic              match;
  logic              last_step;
  logic              accept;

  gene_net_step u_step (
    .state      (cur),
    .next_state (nxt)
  );

  assign accept    = start && (state == IDLE || state == DONE);
  assign last_step = (idx == CW'(MAX_STEPS - 1));

  // Parallel compare of the next state against every valid history entry.
  // Scanning from the top down lets the lowest matching index win.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int i = MAX_STEPS - 1; i >= 0; i--) begin
      if (CW'(i) <= idx && hist[i] == nxt) begin
        match     = 1'b1;
        match_idx = CW'(i);
      end
    end
  end

  // History storage needs no reset: entries above idx are never compared.
  always_ff @(posedge clk) begin
    if (accept) begin
      hist[0] <= seed;
    end else if (state == RUN && !match && !last_step) begin
      for (int i = 1; i < MAX_STEPS; i++) begin
        if (CW'(i) == idx + CW'(1)) hist[i] <= nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      fixed_point <= 1'b0;
      cycle_found <= 1'b0;
      timeout     <= 1'b0;
      period      <= '0;
      transient   <= '0;
      final_state <= '0;
      cur         <= '0;
      idx         <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            cur         <= seed;
            idx         <= '0;
            fixed_point <= 1'b0;
            cycle_found <= 1'b0;
            timeout     <= 1'b0;
            busy        <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          if (match) begin
            // idx >= match_idx, so the period cannot underflow.
            transient   <= match_idx;
            period      <= idx + CW'(1) - match_idx;
            final_state <= nxt;
            fixed_point <= (idx == match_idx);
            cycle_found <= (idx != match_idx);
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= DONE;
          end else if (last_step) begin
            timeout     <= 1'b1;
            period      <= '0;
            transient   <= '0;
            final_state <= cur;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= DONE;
          end else begin
            cur <= nxt;
            idx <= idx + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/gene_net_ctrl.md
# gene_net_ctrl

Attractor-search controller for the 8-gene Boolean regulatory network. It loads a seed state, iterates the synchronous network update one step per clock, and keeps a history of visited states. It stops when the trajectory revisits a state (fixed point or limit cycle) or a step budget runs out. It reports transient length, period and the state at which the revisit was detected. It sits between a host/test sequencer and the network's next-state logic, which it instantiates as a combinational sub-module.

## Interface
- MAX_STEPS, 16: history depth and step budget; legal range 2..64
- CW, $clog2(MAX_STEPS+1): width of count/result fields (derived, not overridden)
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock, synchronous, active-high
- start  in  1  request a search; sampled only in IDLE or DONE
- seed  in  8  initial gene state; sampled with accepted start
- busy  out  1  high while searching (RUN)
- done  out  1  one-cycle pulse when a search ends
- fixed_point  out  1  attractor period == 1
- cycle_found  out  1  attractor period >= 2
- timeout  out  1  budget exhausted, no revisit
- period  out  CW  attractor length; 0 on timeout
- transient  out  CW  history index of first revisited state; 0 on timeout
- final_state  out  8  revisited state (match) or last stored state (timeout)

## Operation
- Next-state function f(s), bit n of result:
  - n0 = ~s2 & s6 & ~s7
  - n1 = (s4|s5) & ~s7
  - n2 = s7
  - n3 = s1 & ~s6
  - n4 = s1|s3
  - n5 = s2 & ~s7
  - n6 = s1 & ~s7
  - n7 = ~(s0|s1) & (s3|s6)
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE + start: hist[0] = seed, cur = seed, idx = 0, result flags cleared, go RUN.
  - RUN, each cycle: nxt = f(cur); compare nxt with hist[0..idx] in parallel.
    - Match at lowest matching index i: transient = i, period = idx+1-i, final_state = nxt, set fixed_point or cycle_found, go DONE.
    - No match and idx == MAX_STEPS-1: timeout = 1, period = transient = 0, final_state = cur, go DONE.
    - No match otherwise: hist[idx+1] = nxt, cur = nxt, idx++.
  - DONE: done = 1 on entry cycle only. Results hold until the next accepted start. Stays in DONE until start (then same as IDLE + start).
- start while RUN: ignored; no queueing.
- Exactly one of fixed_point, cycle_found, timeout is high after a search. All three are low after reset and during RUN.
- Width rule: idx+1-i never underflows, since i <= idx.

## Timing
- Reset value: FSM IDLE. busy, done, fixed_point, cycle_found, timeout = 0. period, transient = 0. final_state = 8'h00. History contents are don't-care.
- rst high mid-RUN: next cycle is IDLE with reset values; the search is aborted and no done is issued.
- start accepted at edge T: busy = 1 from T+1. One evaluation per RUN cycle. A search of k evaluations gives done = 1 and valid results in cycle T+k+1, with busy = 0 in that same cycle.
- Minimum latency (seed is a fixed point): done at T+2. Maximum: T+MAX_STEPS+1.
- start in the DONE cycle itself: accepted; done is still seen for that one cycle.

## Structure
- Package gene_net_pkg:
  - GENE_W = 8
  - FSM state enum (IDLE, RUN, DONE)
  - function gene_next(state), which is the single source of the update rules
- Sub-module gene_net_step: purely combinational wrapper of gene_next, 8 in / 8 out. Reused by other network blocks.
- gene_net_ctrl holds the FSM, history register array, parallel comparators and a priority encoder for the lowest index.

## Test plan
- Reset, then seed 8'h00 with start: done at T+2, fixed_point = 1, period = 1, transient = 0, final_state = 8'h00.
- Seed 8'h04: trajectory 04, 20, 02, 58, 93, 1C, B2, then 1C again. done at T+8, cycle_found = 1, period = 2, transient = 5, final_state = 8'h1C.
- MAX_STEPS = 4, seed 8'h04: timeout = 1, period = 0, transient = 0, final_state = 8'h58, done at T+5.
- Seed 8'h04, pulse start again at T+3 with seed 8'h00: ignored; results identical to the 8'h04 case.
- Seed 8'h04, rst at T+4: busy = 0 and flags = 0 from T+5, no done pulse; a new start with seed 8'h00 then completes normally.
- Back-to-back: start in the DONE cycle of one search with a new seed. Second search starts the next cycle with flags cleared. Scoreboard all 256 seeds against a software model of f.
